// File: rtl/ram_access_ctrl.sv
// Load/store front end for the word-addressed, byte-strobed data RAM.
// Splits misaligned accesses into two word cycles and extends load data.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_rd_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wr_data,
  output logic [3:0]            ram_wr_strobe,
  input  logic [31:0]           ram_rd_data
);

  localparam int BYTE_BITS = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [1:0]            r_off;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic                  r_cross;
  logic [31:0]           r_lo;
  logic [31:0]           r_hi;

  logic [2:0]  w_nbytes;
  logic [32:0] w_last;
  logic        w_fault;
  logic        w_cross;
  logic        w_accept;
  logic [3:0]  w_mask;
  logic [31:0] w_dmask;
  logic [7:0]  w_sframe;
  logic [63:0] w_wframe;
  logic [4:0]  w_shamt;
  logic [31:0] w_rsh;
  logic [31:0] w_ext;

  // Byte count of the incoming request; reserved size is faulted below.
  always_comb begin
    w_nbytes = 3'd4;
    case (req_size)
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // Last byte touched; bit 32 catches wrap past the 32-bit byte space.
  assign w_last  = {1'b0, req_addr} + {30'b0, w_nbytes} - 33'd1;
  assign w_fault = (req_size == 2'b11) ||
                   ((w_last >> BYTE_BITS) != 33'd0);
  assign w_cross = ({1'b0, req_addr[1:0]} + w_nbytes) > 3'd4;
  assign w_accept = (r_state == IDLE) && req_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request capture and read-data buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_off      <= 2'b00;
      r_waddr    <= '0;
      r_wdata    <= 32'h0;
      r_err      <= 1'b0;
      r_cross    <= 1'b0;
      r_lo       <= 32'h0;
      r_hi       <= 32'h0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_off      <= req_addr[1:0];
        r_waddr    <= req_addr[BYTE_BITS-1:2];
        r_wdata    <= req_wdata;
        r_err      <= w_fault;
        r_cross    <= w_cross;
        r_hi       <= 32'h0;
      end
      if (r_state == FIRST && !r_write) begin
        r_lo <= ram_rd_data;
      end
      if (r_state == SECOND && !r_write) begin
        r_hi <= ram_rd_data;
      end
    end
  end

  // Lane masks for the latched size.
  always_comb begin
    w_mask  = 4'b1111;
    w_dmask = 32'hFFFF_FFFF;
    case (r_size)
      2'b00: begin
        w_mask  = 4'b0001;
        w_dmask = 32'h0000_00FF;
      end
      2'b01: begin
        w_mask  = 4'b0011;
        w_dmask = 32'h0000_FFFF;
      end
      default: begin
        w_mask  = 4'b1111;
        w_dmask = 32'hFFFF_FFFF;
      end
    endcase
  end

  // Store data and strobes placed in a two-word frame at the byte offset.
  assign w_shamt  = {r_off, 3'b000};
  assign w_sframe = {4'b0000, w_mask} << r_off;
  assign w_wframe = {32'h0, r_wdata & w_dmask} << w_shamt;
  assign w_rsh    = 32'({r_hi, r_lo} >> w_shamt);

  // Load data truncated to size and extended.
  always_comb begin
    w_ext = w_rsh;
    case (r_size)
      2'b00: begin
        if (r_unsigned) begin
          w_ext = {24'h0, w_rsh[7:0]};
        end else begin
          w_ext = {{24{w_rsh[7]}}, w_rsh[7:0]};
        end
      end
      2'b01: begin
        if (r_unsigned) begin
          w_ext = {16'h0, w_rsh[15:0]};
        end else begin
          w_ext = {{16{w_rsh[15]}}, w_rsh[15:0]};
        end
      end
      default: w_ext = w_rsh;
    endcase
  end

  // Next state and all port outputs.
  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = 32'h0;
    rsp_err       = 1'b0;
    ram_rd_en     = 1'b0;
    ram_wr_en     = 1'b0;
    ram_addr      = '0;
    ram_wr_data   = 32'h0;
    ram_wr_strobe = 4'b0000;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_fault ? RESP : FIRST;
        end
      end
      FIRST: begin
        ram_addr  = r_waddr;
        ram_rd_en = !r_write;
        ram_wr_en = r_write;
        if (r_write) begin
          ram_wr_data   = w_wframe[31:0];
          ram_wr_strobe = w_sframe[3:0];
        end
        w_next = r_cross ? SECOND : RESP;
      end
      SECOND: begin
        ram_addr  = r_waddr + ADDR_WIDTH'(1);
        ram_rd_en = !r_write;
        ram_wr_en = r_write;
        if (r_write) begin
          ram_wr_data   = w_wframe[63:32];
          ram_wr_strobe = w_sframe[7:4];
        end
        w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        rsp_rdata = (r_write || r_err) ? 32'h0 : w_ext;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural RAM,
// a response scoreboard and a log of RAM write cycles.
module tb_ram_access_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          ram_rd_en;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data;
  logic [3:0]    ram_wr_strobe;
  logic [31:0]   ram_rd_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    s;
    logic [31:0]   d;
  } wr_t;

  exp_t sb[$];
  wr_t  wr_log[$];
  logic [31:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int rd0;
  int wr0;
  int lat;
  exp_t e;
  wr_t  wv;

  always #5 clk = ~clk;

  ram_access_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .ram_rd_en     (ram_rd_en),
    .ram_wr_en     (ram_wr_en),
    .ram_addr      (ram_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_strobe (ram_wr_strobe),
    .ram_rd_data   (ram_rd_data)
  );

  assign ram_rd_data = ram_rd_en ? mem[ram_addr] : 32'h0;

  // Behavioural RAM: byte-strobed write, activity counters, write log.
  always @(posedge clk) begin
    if (ram_rd_en) rd_cnt++;
    if (ram_wr_en) begin
      wr_cnt++;
      wr_log.push_back('{ram_addr, ram_wr_strobe, ram_wr_data});
      for (int b = 0; b < 4; b++) begin
        if (ram_wr_strobe[b]) mem[ram_addr][8*b +: 8] = ram_wr_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic get_wr(input int i, output wr_t w);
    w = '{'0, '0, '0};
    if (i < wr_log.size()) w = wr_log[i];
  endtask

  task automatic chk_wr(input string tag, input int i,
                        input logic [AW-1:0] a, input logic [3:0] s,
                        input logic [31:0] d);
    wr_t w;
    get_wr(i, w);
    chk({tag, "_addr"}, 32'(w.a), 32'(a));
    chk({tag, "_strb"}, 32'(w.s), 32'(s));
    chk({tag, "_data"}, w.d, d);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
  endtask

  // Waits for rsp_valid (bounded), then checks against the scoreboard head.
  task automatic wait_rsp(input string tag);
    exp_t x;
    int   l;
    l = 1;
    while (!rsp_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    if (sb.size() == 0) begin
      x = '{32'hx, 1'bx, -1};
    end else begin
      x = sb.pop_front();
    end
    chk({tag, "_lat"}, l, x.lat);
    chk({tag, "_data"}, rsp_rdata, x.rdata);
    chk({tag, "_err"}, 32'(rsp_err), 32'(x.err));
  endtask

  task automatic do_req(input string tag, input logic w,
                        input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input int el);
    sb.push_back('{er, ee, el});
    drive(w, sz, u, a, wd);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp(tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_strobe", 32'(ram_wr_strobe), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Aligned word store then load.
    wr_log.delete();
    do_req("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    chk("st_w_nwr", wr_log.size(), 32'd1);
    chk_wr("st_w", 0, 4, 4'b1111, 32'hDEADBEEF);
    do_req("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

    // Byte store into lane 3, signed and unsigned loads.
    wr_log.delete();
    do_req("st_b", 1, 2'b00, 0, 32'h13, 32'h80, 32'h0, 0, 2);
    chk("st_b_nwr", wr_log.size(), 32'd1);
    chk_wr("st_b", 0, 4, 4'b1000, 32'h80000000);
    do_req("ld_bs", 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 2);
    do_req("ld_bu", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 2);

    // Misaligned half store/load across words 1 and 2.
    wr_log.delete();
    do_req("st_h", 1, 2'b01, 0, 32'h07, 32'hA1B2, 32'h0, 0, 3);
    chk("st_h_nwr", wr_log.size(), 32'd2);
    chk_wr("st_h0", 0, 1, 4'b1000, 32'hB2000000);
    chk_wr("st_h1", 1, 2, 4'b0001, 32'h000000A1);
    do_req("ld_hs", 0, 2'b01, 0, 32'h07, 32'h0, 32'hFFFFA1B2, 0, 3);
    do_req("ld_hu", 0, 2'b01, 1, 32'h07, 32'h0, 32'h0000A1B2, 0, 3);

    // Misaligned word load and word with unsigned flag.
    do_req("ld_wm", 0, 2'b10, 0, 32'h11, 32'h0, 32'h0080ADBE, 0, 3);
    do_req("ld_wu", 0, 2'b10, 1, 32'h10, 32'h0, 32'h80ADBEEF, 0, 2);

    // Top of the byte space is still legal.
    do_req("st_top", 1, 2'b00, 0, 32'hFFF, 32'h5A, 32'h0, 0, 2);
    do_req("ld_top", 0, 2'b10, 0, 32'hFFC, 32'h0, 32'h5A000000, 0, 2);
    do_req("ld_topb", 0, 2'b00, 0, 32'hFFF, 32'h0, 32'h0000005A, 0, 2);

    // Faults: no RAM activity, latency 1.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req("f_oob", 0, 2'b10, 0, 32'hFFD, 32'h0, 32'h0, 1, 1);
    do_req("f_sz3", 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1, 1);
    do_req("f_sz3w", 1, 2'b11, 0, 32'h20, 32'hFF, 32'h0, 1, 1);
    do_req("f_wrap", 0, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 32'h0, 1, 1);
    do_req("f_hend", 0, 2'b01, 0, 32'hFFF, 32'h0, 32'h0, 1, 1);
    chk("f_no_rd", rd_cnt - rd0, 32'd0);
    chk("f_no_wr", wr_cnt - wr0, 32'd0);

    // Backpressure: response held, new request ignored.
    wr0 = wr_cnt;
    sb.push_back('{32'h80ADBEEF, 1'b0, 2});
    drive(0, 2'b10, 0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rsp("bp");
    drive(1, 2'b10, 0, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_rdata, 32'h80ADBEEF);
      chk("bp_rdy", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_done_valid", 32'(rsp_valid), 32'd0);
    chk("bp_done_rdy", 32'(req_ready), 32'd1);
    chk("bp_no_wr", wr_cnt - wr0, 32'd0);

    // Reset during the second half of a split store.
    do_req("st_w3", 1, 2'b10, 0, 32'h0C, 32'h12345678, 32'h0, 0, 2);
    drive(1, 2'b01, 0, 32'h0B, 32'h5566);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rs_f_wr", 32'(ram_wr_en), 32'd1);
    chk("rs_f_addr", 32'(ram_addr), 32'd2);
    chk("rs_f_strb", 32'(ram_wr_strobe), 32'b1000);
    @(posedge clk);
    #1;
    chk("rs_s_wr", 32'(ram_wr_en), 32'd1);
    chk("rs_s_addr", 32'(ram_addr), 32'd3);
    rst = 1'b1;
    #1;
    chk("rs_wr_off", 32'(ram_wr_en), 32'd0);
    chk("rs_rsp_off", 32'(rsp_valid), 32'd0);
    chk("rs_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_req("rs_w3", 0, 2'b10, 0, 32'h0C, 32'h0, 32'h12345678, 0, 2);
    do_req("rs_w2", 0, 2'b10, 0, 32'h08, 32'h0, 32'h660000A1, 0, 2);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Load/store front end for the word-addressable, byte-strobed data RAM. Accepts byte-addressed CPU memory requests over a valid/ready handshake and drives the RAM port. Handles byte, half and word sizes, splits misaligned accesses into two word accesses, aligns write data and strobes, and sign- or zero-extends read data. Sits between the core's load/store unit and the RAM; returns one response per request.

Parameters:
ADDR_WIDTH, DEFAULT_RAM_ADDR_WIDTH, RAM word-address bits; byte space is 2^(ADDR_WIDTH+2) bytes

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  zero-extend loads when 1
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access fault
ram_rd_en  output  1  RAM read enable
ram_wr_en  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM word address
ram_wr_data  output  32  RAM write data
ram_wr_strobe  output  4  RAM byte strobes
ram_rd_data  input  32  RAM read data, combinational from ram_addr/ram_rd_en

Behaviour:
- States: IDLE, FIRST, SECOND, RESP. Reset -> IDLE. All outputs 0 in reset except req_ready=1 (IDLE).
- IDLE: req_ready=1. On req_valid, latch request fields. Then:
  - Fault if size=11, or last byte (addr+nbytes-1) >= 2^(ADDR_WIDTH+2), or carry out of 32 bits. Fault -> RESP with rsp_err=1, rdata=0; no RAM access.
  - Otherwise -> FIRST.
- FIRST: ram_addr = addr[ADDR_WIDTH+1:2]. Loads: ram_rd_en=1; capture ram_rd_data into lo buffer at cycle end. Stores: ram_wr_en=1, strobe = low nibble of (size mask << addr[1:0]). Data = low word of (wdata << 8*addr[1:0]) in a 64-bit frame.
  - Next SECOND if the access crosses a word boundary (offset+nbytes > 4), else RESP.
- SECOND: ram_addr = first word + 1. Loads capture into hi buffer. Stores use the upper nibble/upper word of the shifted frame. Next RESP.
- RAM strobes/enables are 0 outside FIRST/SECOND. The strobe is never 0 when wr_en=1.
- RESP: rsp_valid=1. rsp_rdata = ({hi,lo} >> 8*offset) truncated to size, then sign-extended (req_unsigned=0) or zero-extended. Stores return rdata=0, err=0.
  - Hold until rsp_ready, then IDLE. req_ready=0 in RESP; no back-to-back overlap.
- Latency from accept edge: aligned / non-crossing -> rsp_valid 2 cycles later; crossing -> 3; fault -> 1.
- rsp_valid/rdata/err are stable while rsp_valid=1 and rsp_ready=0.
- Size=word with unsigned flag: no effect.
- Reset mid-operation: immediately returns to IDLE.
  - A pending SECOND write of a split store is not performed (partial store allowed; the first half may already be written).
  - A pending response is dropped.

Test Plan:
- Aligned word store addr 0x10, wdata 0xDEADBEEF, then load word 0x10 -> one write, word 4, strobe 1111; load returns 0xDEADBEEF 2 cycles after accept, err=0.
- Byte store 0x80 at 0x13, then signed byte load 0x13 -> strobe 1000, wr_data[31:24]=0x80; load rdata 0xFFFFFF80; unsigned load rdata 0x00000080.
- Misaligned half store 0xA1B2 at 0x07 -> FIRST word 1 strobe 1000 data[31:24]=0xB2; SECOND word 2 strobe 0001 data[7:0]=0xA1. Signed half load 0x07 -> 0xFFFFA1B2, 3 cycles latency.
- Word load at last word plus 1 byte (byte addr 2^(ADDR_WIDTH+2)-3) and size=11 -> rsp_err=1, rdata=0, no ram_rd_en/ram_wr_en pulse, latency 1.
- Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0, new req_valid ignored until handshake.
- Assert rst during SECOND of a split store -> ram_wr_en=0 immediately, state IDLE, rsp_valid=0, second word unchanged.
